// File: rtl/reaction_pkg.sv
// reaction_pkg: shared 7-segment patterns and display mode encoding
package reaction_pkg;

    typedef enum logic {
        MODE_NORMAL = 1'b0,
        MODE_ERR    = 1'b1
    } mode_t;

    // Active-low {dp,g,f,e,d,c,b,a}; element n is the pattern for digit n
    localparam logic [9:0][7:0] SSEG_DIGITS = {
        8'h90, 8'h80, 8'hF8, 8'h82, 8'h92,
        8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };
    localparam logic [7:0] SSEG_DASH  = 8'hBF;
    localparam logic [7:0] SSEG_BLANK = 8'hFF;
    localparam logic [7:0] SSEG_ERR_E = 8'h86;

endpackage

// File: rtl/bcd_to_sseg.sv
// bcd_to_sseg: BCD nibble to active-low 7-segment pattern, 'E' for non-BCD codes
module bcd_to_sseg
    import reaction_pkg::*;
(
    input  logic [3:0] nib,
    output logic [7:0] sseg
);

    // Non-decimal nibbles are shown as 'E' so corrupted results are visible
    always_comb begin
        sseg = (nib > 4'd9) ? SSEG_ERR_E : SSEG_DIGITS[nib];
    end

endmodule

// File: rtl/reaction_display.sv
// reaction_display: captures the BCD reaction time and scans it onto a 4-digit 7-segment display
module reaction_display
    import reaction_pkg::*;
#(
    parameter int REFRESH_N = 18,
    parameter int BLINK_N   = 26,
    parameter int LZB       = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] times,
    input  logic        times_valid,
    input  logic        err_early,
    input  logic        clear,
    output logic [3:0]  an,
    output logic [7:0]  sseg
);

    logic [15:0]          shadow;
    mode_t                mode;
    logic [REFRESH_N-1:0] refresh_cnt;
    logic [BLINK_N-1:0]   blink_cnt;
    logic [1:0]           sel;
    logic [3:0]           nib;
    logic [7:0]           pat;
    logic                 blank;
    logic [3:0]           digit_en;

    assign sel = refresh_cnt[REFRESH_N-1 -: 2];

    // Every digit is read from the one shadow register, so a new result never tears
    always_comb begin
        nib      = shadow[{sel, 2'b00} +: 4];
        blank    = (LZB != 0) && (sel != 2'd0) && ((shadow >> {sel, 2'b00}) == 16'h0000);
        digit_en = ~(4'b0001 << sel);
    end

    bcd_to_sseg u_dec (
        .nib  (nib),
        .sseg (pat)
    );

    // Result capture and mode: clear beats a new result, which beats an early-press fault
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow <= 16'h0000;
            mode   <= MODE_NORMAL;
        end else if (clear) begin
            shadow <= 16'h0000;
            mode   <= MODE_NORMAL;
        end else if (times_valid) begin
            shadow <= times;
            mode   <= MODE_NORMAL;
        end else if (err_early) begin
            mode   <= MODE_ERR;
        end
    end

    // Free-running scan and blink counters; the blink phase is independent of mode changes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            refresh_cnt <= '0;
            blink_cnt   <= '0;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
            blink_cnt   <= blink_cnt + 1'b1;
        end
    end

    // Registered pin drive: one digit enabled at a time, all dark in the fault blink-off phase
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            an   <= 4'hF;
            sseg <= SSEG_BLANK;
        end else begin
            an   <= (mode == MODE_ERR && blink_cnt[BLINK_N-1]) ? 4'hF : digit_en;
            sseg <= (mode == MODE_ERR) ? SSEG_DASH : blank ? SSEG_BLANK : pat;
        end
    end

endmodule

// File: tb/tb_reaction_display.sv
// tb_reaction_display: table vectors, corner sequences and random traffic against a cycle model
module tb_reaction_display;

    localparam int RN = 4;
    localparam int BN = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] times = 16'h0000;
    logic        times_valid = 1'b0;
    logic        err_early = 1'b0;
    logic        clear = 1'b0;
    logic [3:0]  an1, an0;
    logic [7:0]  s1, s0;

    int checks = 0;
    int failures = 0;
    bit auto_chk = 1'b0;

    always #5 clk = ~clk;

    reaction_display #(.REFRESH_N(RN), .BLINK_N(BN), .LZB(1)) dut (
        .clk(clk), .reset(reset), .times(times), .times_valid(times_valid),
        .err_early(err_early), .clear(clear), .an(an1), .sseg(s1)
    );

    reaction_display #(.REFRESH_N(RN), .BLINK_N(BN), .LZB(0)) dut0 (
        .clk(clk), .reset(reset), .times(times), .times_valid(times_valid),
        .err_early(err_early), .clear(clear), .an(an0), .sseg(s0)
    );

    logic [7:0] tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                             8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] digit_exp(input logic [15:0] sh, input bit err,
                                             input int k, input bit lzb);
        logic [3:0] n;
        if (err) return 8'hBF;
        if (lzb && k > 0 && (sh >> (4 * k)) == 16'h0) return 8'hFF;
        n = sh[4 * k +: 4];
        return (n > 9) ? 8'h86 : tbl[n];
    endfunction

    // Reference model: result, fault flag and cycles since reset release
    logic [15:0] m_shadow = 16'h0;
    bit          m_err = 1'b0;
    int          cyc = 0;
    logic [3:0]  x_an = 4'hF;
    logic [7:0]  x_s1 = 8'hFF;
    logic [7:0]  x_s0 = 8'hFF;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_shadow = 16'h0;
            m_err = 1'b0;
            cyc = 0;
            x_an = 4'hF;
            x_s1 = 8'hFF;
            x_s0 = 8'hFF;
        end else begin
            int k;
            k = (cyc / (1 << (RN - 2))) % 4;
            x_an = (m_err && ((cyc / (1 << (BN - 1))) % 2) == 1) ? 4'hF : ~(4'b0001 << k);
            x_s1 = digit_exp(m_shadow, m_err, k, 1'b1);
            x_s0 = digit_exp(m_shadow, m_err, k, 1'b0);
            if (clear) begin
                m_shadow = 16'h0;
                m_err = 1'b0;
            end else if (times_valid) begin
                m_shadow = times;
                m_err = 1'b0;
            end else if (err_early) begin
                m_err = 1'b1;
            end
            cyc++;
        end
    end

    always @(negedge clk) begin
        if (auto_chk) begin
            chk("model_an_lzb1", {28'h0, an1}, {28'h0, x_an});
            chk("model_an_lzb0", {28'h0, an0}, {28'h0, x_an});
            chk("model_sseg_lzb1", {24'h0, s1}, {24'h0, x_s1});
            chk("model_sseg_lzb0", {24'h0, s0}, {24'h0, x_s0});
        end
    end

    task automatic load(input logic [15:0] t);
        @(negedge clk);
        times = t;
        times_valid = 1'b1;
        @(negedge clk);
        times_valid = 1'b0;
    endtask

    // Walk one full scan and compare each digit against {d3,d2,d1,d0} expectations
    task automatic scan_check(input string name, input logic [31:0] e1, input logic [31:0] e0);
        for (int k = 0; k < 4; k++) begin
            logic [3:0] want;
            int n;
            want = ~(4'b0001 << k);
            n = 0;
            @(negedge clk);
            while (an1 !== want && n < 40) begin
                @(negedge clk);
                n++;
            end
            if (n >= 40) begin
                checks++;
                failures++;
                $display("FAIL %s_timeout digit=%0d an=%b required=%b", name, k, an1, want);
            end else begin
                chk({name, "_lzb1"}, {24'h0, s1}, {24'h0, e1[8 * k +: 8]});
                chk({name, "_lzb0"}, {24'h0, s0}, {24'h0, e0[8 * k +: 8]});
            end
        end
    endtask

    typedef struct {
        logic [15:0] t;
        logic [31:0] e1;
        logic [31:0] e0;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int nb, nd;
        vecs.push_back('{16'h0253, 32'hFFA492B0, 32'hC0A492B0});
        vecs.push_back('{16'h1000, 32'hF9C0C0C0, 32'hF9C0C0C0});
        vecs.push_back('{16'h0007, 32'hFFFFFFF8, 32'hC0C0C0F8});
        vecs.push_back('{16'h0A12, 32'hFF86F9A4, 32'hC086F9A4});
        vecs.push_back('{16'h9999, 32'h90909090, 32'h90909090});
        vecs.push_back('{16'h0042, 32'hFFFF99A4, 32'hC0C099A4});
        vecs.push_back('{16'h0000, 32'hFFFFFFC0, 32'hC0C0C0C0});

        #2 reset = 1'b0;
        #1;
        chk("reset_an", {28'h0, an1}, 32'hF);
        chk("reset_sseg", {24'h0, s1}, 32'hFF);
        chk("reset_an0", {28'h0, an0}, 32'hF);
        chk("reset_sseg0", {24'h0, s0}, 32'hFF);
        @(negedge clk);
        reset = 1'b1;
        auto_chk = 1'b1;
        scan_check("after_reset", 32'hFFFFFFC0, 32'hC0C0C0C0);

        foreach (vecs[i]) begin
            load(vecs[i].t);
            scan_check($sformatf("vec_%h", vecs[i].t), vecs[i].e1, vecs[i].e0);
        end

        @(negedge clk);
        err_early = 1'b1;
        @(negedge clk);
        err_early = 1'b0;
        nb = 0;
        nd = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (an1 === 4'hF) nb++;
            else begin
                nd++;
                chk("err_dash", {24'h0, s1}, 32'hBF);
            end
        end
        chk("err_blank_phase_seen", nb > 0, 1);
        chk("err_dash_phase_seen", nd > 0, 1);
        load(16'h0042);
        scan_check("after_err", 32'hFFFF99A4, 32'hC0C099A4);

        load(16'h0253);
        @(negedge clk);
        times = 16'h0777;
        times_valid = 1'b1;
        err_early = 1'b1;
        clear = 1'b1;
        @(negedge clk);
        times_valid = 1'b0;
        err_early = 1'b0;
        clear = 1'b0;
        scan_check("all_strobes", 32'hFFFFFFC0, 32'hC0C0C0C0);

        clear = 1'b1;
        load(16'h1234);
        @(negedge clk);
        err_early = 1'b1;
        @(negedge clk);
        err_early = 1'b0;
        scan_check("clear_held", 32'hFFFFFFC0, 32'hC0C0C0C0);
        clear = 1'b0;

        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            times = {4'($urandom_range(0, 11)), 4'($urandom_range(0, 11)),
                     4'($urandom_range(0, 11)), 4'($urandom_range(0, 11))};
            if ($urandom_range(0, 2) == 0) times[15:8] = 8'h00;
            times_valid = ($urandom_range(0, 5) == 0);
            err_early = ($urandom_range(0, 9) == 0);
            clear = ($urandom_range(0, 24) == 0);
        end
        @(negedge clk);
        times_valid = 1'b0;
        err_early = 1'b0;
        clear = 1'b0;

        load(16'h0253);
        repeat (6) @(negedge clk);
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("async_reset_an", {28'h0, an1}, 32'hF);
        chk("async_reset_sseg", {24'h0, s1}, 32'hFF);
        chk("async_reset_sseg0", {24'h0, s0}, 32'hFF);
        @(negedge clk);
        reset = 1'b1;
        scan_check("after_midscan_reset", 32'hFFFFFFC0, 32'hC0C0C0C0);

        auto_chk = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
